// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table response checker.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        SETTLING = 2'd2,
        DONE     = 2'd3
    } tt_state_t;

    // Settle interval range is 0..15, so four bits cover it.
    localparam int SETTLE_W = 4;

    // Table depth for a circuit with n_in inputs.
    function automatic int depth(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable settle down-counter. The expire flag marks the cycle in which
// the running count steps onto zero, which is the cycle the output is sampled.
module tt_settle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         expire
);

    logic [W-1:0] count;

    // Count register: clear wins over load, load wins over decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    // A count of 0 in SETTLING cannot occur normally; treating it as expired
    // keeps the FSM from ever stalling there.
    assign expire = (count <= W'(1));

endmodule

// File: rtl/truth_table_checker.sv
// Observes an exhaustive stimulus sweep, samples the circuit output after a
// settle interval, builds the observed truth table and compares it against
// the expected table.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset, waiting for start
// ARMED    | run in progress, waiting for the next applied vector
// SETTLING | vector latched, counting down before sampling dut_out
// DONE     | every vector seen at least once; results held until start
module truth_table_checker
    import tt_pkg::*;
#(
    parameter int                 N_IN      = 4,
    localparam int                DEPTH     = depth(N_IN),
    parameter logic [DEPTH-1:0]   EXP_TABLE = '0,
    parameter int                 SETTLE    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_IN-1:0]   vec_in,
    input  logic              vec_valid,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_err_vec,
    output logic              first_err_valid,
    output logic              overrun,
    output logic [DEPTH-1:0]  obs_table
);

    tt_state_t         state;
    tt_state_t         state_nxt;

    logic [DEPTH-1:0]  seen;
    logic [N_IN-1:0]   cur_vec;

    logic              run_start;
    logic              accept;
    logic              sample;
    logic              ovr_hit;
    logic              tmr_expire;

    logic [N_IN-1:0]   samp_vec;
    logic [DEPTH-1:0]  samp_mask;
    logic              all_seen_nxt;
    logic              mismatch;

    // With no settle interval the sample is taken straight from the
    // vector being applied; otherwise from the latched copy.
    assign samp_vec     = (state == ARMED) ? vec_in : cur_vec;
    assign samp_mask    = DEPTH'(1) << samp_vec;
    assign all_seen_nxt = &(seen | samp_mask);
    assign mismatch     = (dut_out != EXP_TABLE[samp_vec]);

    tt_settle_timer #(
        .W (SETTLE_W)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (run_start),
        .load     (accept),
        .load_val (SETTLE_W'(SETTLE)),
        .dec      (state == SETTLING),
        .expire   (tmr_expire)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_nxt = state;
        run_start = 1'b0;
        accept    = 1'b0;
        sample    = 1'b0;
        ovr_hit   = 1'b0;
        case (state)
            IDLE, DONE: begin
                // start takes priority; a coincident vector is ignored.
                if (start) begin
                    run_start = 1'b1;
                    state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (vec_valid) begin
                    accept = 1'b1;
                    if (SETTLE == 0) begin
                        sample    = 1'b1;
                        state_nxt = all_seen_nxt ? DONE : ARMED;
                    end else begin
                        state_nxt = SETTLING;
                    end
                end
            end
            SETTLING: begin
                // A new vector here, even on the final settle cycle, is
                // dropped and flagged; the pending sample still completes.
                if (vec_valid) begin
                    ovr_hit = 1'b1;
                end
                if (tmr_expire) begin
                    sample    = 1'b1;
                    state_nxt = all_seen_nxt ? DONE : ARMED;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture datapath: observed table, seen mask, error bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen            <= '0;
            cur_vec         <= '0;
            obs_table       <= '0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
            overrun         <= 1'b0;
        end else if (run_start) begin
            seen            <= '0;
            cur_vec         <= '0;
            obs_table       <= '0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            if (accept) begin
                cur_vec <= vec_in;
            end
            if (ovr_hit) begin
                overrun <= 1'b1;
            end
            if (sample) begin
                obs_table[samp_vec] <= dut_out;
                seen                <= seen | samp_mask;
                // Errors are counted once per unique vector; repeats only
                // refresh the observed table.
                if (!seen[samp_vec] && mismatch) begin
                    err_count <= err_count + 1'b1;
                    if (!first_err_valid) begin
                        first_err_vec   <= samp_vec;
                        first_err_valid <= 1'b1;
                    end
                end
            end
        end
    end

    assign busy = (state == ARMED) || (state == SETTLING);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_count == '0);

endmodule
